// File: rtl/gb_frame_bank_scheduler_if.sv
// ----------------------------------------------------------------------------
// gb_frame_bank_scheduler_if
//   Bundle between the LCD pixel conduit, the frame RAM write port and the VGA
//   read-bank select of the triple-buffer scheduler.
//
//   Handshake: the pixel stream is valid-only. px_valid has no ready/backpressure;
//   a pixel is consumed on every clk edge where px_valid is high, and px_data is
//   only meaningful in that cycle. lcd_frame_start and disp_vsync are single-cycle
//   pulses sampled on the same edge.
//
//   master : pixel/sync source (drives px_*, lcd_frame_start, disp_vsync, freeze)
//   slave  : the scheduler (drives wr_*, rd_bank, counters and debug state)
//
//   Signals
//     px_valid, px_data[1:0], lcd_frame_start, disp_vsync, freeze   -> scheduler
//     wr_en, wr_bank[1:0], wr_addr[ADDR_W-1:0], wr_data[1:0]          <- scheduler
//     rd_bank[1:0], dropped_cnt, repeat_cnt, sync_err_cnt [15:0]      <- scheduler
//     dbg_w_bank, dbg_p_bank [1:0], dbg_pend_valid                    <- scheduler
// ----------------------------------------------------------------------------
interface gb_frame_bank_scheduler_if #(
  parameter int ADDR_W = 15
);
  logic              px_valid;
  logic [1:0]        px_data;
  logic              lcd_frame_start;
  logic              disp_vsync;
  logic              freeze;

  logic              wr_en;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic [1:0]        rd_bank;
  logic [15:0]       dropped_cnt;
  logic [15:0]       repeat_cnt;
  logic [15:0]       sync_err_cnt;

  // Bank-role state, exposed so checkers can see W/P/pending directly.
  logic [1:0]        dbg_w_bank;
  logic [1:0]        dbg_p_bank;
  logic              dbg_pend_valid;

  modport master (
    output px_valid, px_data, lcd_frame_start, disp_vsync, freeze,
    input  wr_en, wr_bank, wr_addr, wr_data, rd_bank,
           dropped_cnt, repeat_cnt, sync_err_cnt,
           dbg_w_bank, dbg_p_bank, dbg_pend_valid
  );

  modport slave (
    input  px_valid, px_data, lcd_frame_start, disp_vsync, freeze,
    output wr_en, wr_bank, wr_addr, wr_data, rd_bank,
           dropped_cnt, repeat_cnt, sync_err_cnt,
           dbg_w_bank, dbg_p_bank, dbg_pend_valid
  );
endinterface

// File: rtl/gb_frame_bank_scheduler.sv
// ----------------------------------------------------------------------------
// gb_frame_bank_scheduler
//   Triple-buffer scheduler for the GameBoy LCD framebuffer. Converts the 2-bit
//   pixel stream into frame-RAM write strobes (bank + linear address y*GB_W+x)
//   and selects the bank the VGA scaler reads. The read bank only changes on
//   display vsync, so the displayed picture never tears.
//
//   Three banks play the roles W (being written), R (being displayed) and
//   P (pending: last completed frame, valid when pend_valid=1). {W,R,P} is
//   always a permutation of {0,1,2}.
//
//   Ports
//     clk    : single clock
//     reset  : synchronous, active-high; wins over every other input
//     bus    : gb_frame_bank_scheduler_if.slave (pixel input, RAM write
//              port, rd_bank, saturating event counters, debug state)
// ----------------------------------------------------------------------------
module gb_frame_bank_scheduler #(
  parameter int GB_W   = 160,
  parameter int GB_H   = 144,
  parameter int ADDR_W = 15
) (
  input logic                      clk,
  input logic                      reset,
  gb_frame_bank_scheduler_if.slave bus
);

  localparam int              FRAME_PX = GB_W * GB_H;
  localparam logic [ADDR_W-1:0] LAST_PX = ADDR_W'(FRAME_PX - 1);

  // Role registers
  logic [1:0]        w_q, r_q, p_q;
  logic              pend_q;
  logic [ADDR_W-1:0] cnt_q;

  // Registered write port
  logic              wr_en_q;
  logic [1:0]        wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [1:0]        wr_data_q;

  // Event counters
  logic [15:0]       dropped_q, repeat_q, sync_err_q;

  // Next-state values
  logic [1:0]        w_n, r_n, p_n;
  logic              pend_n;
  logic [ADDR_W-1:0] cnt_n;
  logic [ADDR_W-1:0] pix_addr;
  logic              sync_abort;
  logic              frame_done;
  logic              vsync_live;
  logic              inc_dropped, inc_repeat, inc_sync;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    sat_inc = (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    w_n         = w_q;
    r_n         = r_q;
    p_n         = p_q;
    pend_n      = pend_q;
    inc_dropped = 1'b0;
    inc_repeat  = 1'b0;

    // A frame start with a partial frame in flight abandons it; a pixel in the
    // same cycle becomes pixel 0 of the new frame. With cnt==0 it changes nothing.
    sync_abort = bus.lcd_frame_start && (cnt_q != '0);
    inc_sync   = sync_abort;
    pix_addr   = bus.lcd_frame_start ? '0 : cnt_q;

    frame_done = bus.px_valid && (pix_addr == LAST_PX);

    if (bus.px_valid) begin
      cnt_n = frame_done ? '0 : pix_addr + ADDR_W'(1);
    end else begin
      cnt_n = pix_addr;
    end

    // Completion is applied before vsync so a frame finishing on the vsync
    // edge is displayed immediately.
    if (frame_done) begin
      w_n         = p_q;
      p_n         = w_q;
      pend_n      = 1'b1;
      inc_dropped = pend_q;
    end

    vsync_live = bus.disp_vsync && !bus.freeze;
    if (vsync_live) begin
      if (pend_n) begin
        r_n    = p_n;
        p_n    = r_q;
        pend_n = 1'b0;
      end else begin
        inc_repeat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q        <= 2'd0;
      r_q        <= 2'd1;
      p_q        <= 2'd2;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 2'd0;
      wr_addr_q  <= '0;
      wr_data_q  <= 2'd0;
      dropped_q  <= 16'd0;
      repeat_q   <= 16'd0;
      sync_err_q <= 16'd0;
    end else begin
      wr_en_q <= bus.px_valid;
      if (bus.px_valid) begin
        // The last pixel of a frame still lands in the old W bank.
        wr_bank_q <= w_q;
        wr_addr_q <= pix_addr;
        wr_data_q <= bus.px_data;
      end
      w_q        <= w_n;
      r_q        <= r_n;
      p_q        <= p_n;
      pend_q     <= pend_n;
      cnt_q      <= cnt_n;
      dropped_q  <= sat_inc(dropped_q, inc_dropped);
      repeat_q   <= sat_inc(repeat_q, inc_repeat);
      sync_err_q <= sat_inc(sync_err_q, inc_sync);
    end
  end

  assign bus.wr_en          = wr_en_q;
  assign bus.wr_bank        = wr_bank_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.rd_bank        = r_q;
  assign bus.dropped_cnt    = dropped_q;
  assign bus.repeat_cnt     = repeat_q;
  assign bus.sync_err_cnt   = sync_err_q;
  assign bus.dbg_w_bank     = w_q;
  assign bus.dbg_p_bank     = p_q;
  assign bus.dbg_pend_valid = pend_q;

endmodule

// File: tb/tb_gb_frame_bank_scheduler.sv
module tb_gb_frame_bank_scheduler;

  localparam int GB_W   = 4;
  localparam int GB_H   = 2;
  localparam int ADDR_W = 15;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  gb_frame_bank_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  gb_frame_bank_scheduler #(
    .GB_W  (GB_W),
    .GB_H  (GB_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the active edge; outputs are sampled there.
  task automatic drive(input logic pv, input logic [1:0] d, input logic st, input logic vs);
    bus.px_valid        = pv;
    bus.px_data         = d;
    bus.lcd_frame_start = st;
    bus.disp_vsync      = vs;
    @(posedge clk);
    #1;
    bus.px_valid        = 1'b0;
    bus.px_data         = 2'd0;
    bus.lcd_frame_start = 1'b0;
    bus.disp_vsync      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_en"},   32'(bus.wr_en),          32'd0);
    chk({tag, "_wr_bank"}, 32'(bus.wr_bank),        32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr),        32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data),        32'd0);
    chk({tag, "_rd_bank"}, 32'(bus.rd_bank),        32'd1);
    chk({tag, "_dropped"}, 32'(bus.dropped_cnt),    32'd0);
    chk({tag, "_repeat"},  32'(bus.repeat_cnt),     32'd0);
    chk({tag, "_syncerr"}, 32'(bus.sync_err_cnt),   32'd0);
    chk({tag, "_w"},       32'(bus.dbg_w_bank),     32'd0);
    chk({tag, "_p"},       32'(bus.dbg_p_bank),     32'd2);
    chk({tag, "_pend"},    32'(bus.dbg_pend_valid), 32'd0);
  endtask

  // Roles must stay a permutation of {0,1,2}
  task automatic chk_distinct(input string tag);
    chk({tag, "_w_ne_r"}, 32'(bus.dbg_w_bank != bus.rd_bank),    32'd1);
    chk({tag, "_w_ne_p"}, 32'(bus.dbg_w_bank != bus.dbg_p_bank), 32'd1);
    chk({tag, "_r_ne_p"}, 32'(bus.rd_bank != bus.dbg_p_bank),    32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b0;
    bus.px_valid        = 1'b0;
    bus.px_data         = 2'd0;
    bus.lcd_frame_start = 1'b0;
    bus.disp_vsync      = 1'b0;
    bus.freeze          = 1'b0;
    #2;

    // 1: reset, then one full frame into bank 0
    do_reset();
    chk_reset_state("t1_reset");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0);
      chk($sformatf("t1_px%0d_en", i),   32'(bus.wr_en),   32'd1);
      chk($sformatf("t1_px%0d_addr", i), 32'(bus.wr_addr), 32'(i));
      chk($sformatf("t1_px%0d_bank", i), 32'(bus.wr_bank), 32'd0);
      chk($sformatf("t1_px%0d_data", i), 32'(bus.wr_data), 32'(i % 4));
    end
    chk("t1_w",    32'(bus.dbg_w_bank),     32'd2);
    chk("t1_p",    32'(bus.dbg_p_bank),     32'd0);
    chk("t1_pend", 32'(bus.dbg_pend_valid), 32'd1);
    chk("t1_rd",   32'(bus.rd_bank),        32'd1);
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t1_idle_en",   32'(bus.wr_en),   32'd0);
    chk("t1_idle_addr", 32'(bus.wr_addr), 32'd7);
    chk("t1_idle_data", 32'(bus.wr_data), 32'd3);

    // 2: vsync shows the pending frame; a second vsync repeats
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t2_rd",     32'(bus.rd_bank),        32'd0);
    chk("t2_p",      32'(bus.dbg_p_bank),     32'd1);
    chk("t2_pend",   32'(bus.dbg_pend_valid), 32'd0);
    chk("t2_repeat", 32'(bus.repeat_cnt),     32'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t2_rd2",     32'(bus.rd_bank),    32'd0);
    chk("t2_repeat2", 32'(bus.repeat_cnt), 32'd1);

    // 3: three frames with no vsync; W alternates 2,0,2
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        chk($sformatf("t3_f%0d_px%0d_rd", f, i), 32'(bus.rd_bank), 32'd1);
        chk_distinct($sformatf("t3_f%0d_px%0d", f, i));
      end
      chk($sformatf("t3_f%0d_w", f),       32'(bus.dbg_w_bank),  (f % 2 == 0) ? 32'd2 : 32'd0);
      chk($sformatf("t3_f%0d_dropped", f), 32'(bus.dropped_cnt), 32'(f));
    end
    chk("t3_dropped", 32'(bus.dropped_cnt), 32'd2);
    chk("t3_pend",    32'(bus.dbg_pend_valid), 32'd1);

    // 4: early frame start with a pixel in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd2, 1'b0, 1'b0);
    chk("t4_pre_addr", 32'(bus.wr_addr), 32'd4);
    drive(1'b1, 2'd3, 1'b1, 1'b0);
    chk("t4_syncerr", 32'(bus.sync_err_cnt),   32'd1);
    chk("t4_addr",    32'(bus.wr_addr),        32'd0);
    chk("t4_data",    32'(bus.wr_data),        32'd3);
    chk("t4_bank",    32'(bus.wr_bank),        32'd0);
    chk("t4_w",       32'(bus.dbg_w_bank),     32'd0);
    chk("t4_pend",    32'(bus.dbg_pend_valid), 32'd0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    chk("t4_next_addr", 32'(bus.wr_addr), 32'd1);
    // frame start at cnt==0 is a no-op (cnt now 2, so realign first via a full wrap)
    for (int i = 0; i < 6; i++) drive(1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    chk("t4_start_at0_syncerr", 32'(bus.sync_err_cnt), 32'd1);
    chk("t4_wrapped_w",         32'(bus.dbg_w_bank),   32'd2);

    // 5: last pixel coincides with vsync
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b1);
    chk("t5_w",       32'(bus.dbg_w_bank),     32'd2);
    chk("t5_rd",      32'(bus.rd_bank),        32'd0);
    chk("t5_p",       32'(bus.dbg_p_bank),     32'd1);
    chk("t5_pend",    32'(bus.dbg_pend_valid), 32'd0);
    chk("t5_last_bk", 32'(bus.wr_bank),        32'd0);
    chk("t5_last_ad", 32'(bus.wr_addr),        32'd7);
    chk("t5_dropped", 32'(bus.dropped_cnt),    32'd0);
    chk("t5_repeat",  32'(bus.repeat_cnt),     32'd0);
    chk("t5_syncerr", 32'(bus.sync_err_cnt),   32'd0);

    // 6: freeze holds the picture; then reset mid-frame
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 2'd3, 1'b0, 1'b0);
    bus.freeze = 1'b1;
    for (int v = 0; v < 3; v++) begin
      drive(1'b0, 2'd0, 1'b0, 1'b1);
      chk($sformatf("t6_v%0d_rd", v),     32'(bus.rd_bank),        32'd1);
      chk($sformatf("t6_v%0d_pend", v),   32'(bus.dbg_pend_valid), 32'd1);
      chk($sformatf("t6_v%0d_repeat", v), 32'(bus.repeat_cnt),     32'd0);
      chk($sformatf("t6_v%0d_drop", v),   32'(bus.dropped_cnt),    32'd0);
    end
    bus.freeze = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, 1'b0, 1'b0);
    chk("t6_mid_bank", 32'(bus.wr_bank), 32'd2);
    chk("t6_mid_addr", 32'(bus.wr_addr), 32'd2);
    bus.px_valid = 1'b1;
    bus.px_data  = 2'd3;
    do_reset();
    bus.px_valid = 1'b0;
    bus.px_data  = 2'd0;
    chk_reset_state("t6_reset");
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    chk("t6_after_addr", 32'(bus.wr_addr), 32'd0);
    chk("t6_after_bank", 32'(bus.wr_bank), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
